// File: rtl/riscv_dmi_arbiter.sv
// Two-requester DMI arbiter: round-robin grant of a single outstanding DMI
// transaction to the Debug Module, with a per-transaction timeout abort.
module riscv_dmi_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned DMI_ADDR_WIDTH = 7,
  parameter int unsigned DMI_DATA_WIDTH = 32,
  parameter int unsigned DMI_OP_WIDTH   = 2
) (
  input  logic                           clk_i,
  input  logic                           trst_i,
  input  logic [1:0]                     req_valid_i,
  output logic [1:0]                     req_ready_o,
  input  logic [1:0][DMI_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [1:0][DMI_DATA_WIDTH-1:0] req_data_i,
  input  logic [1:0][DMI_OP_WIDTH-1:0]   req_op_i,
  output logic [1:0]                     resp_valid_o,
  input  logic [1:0]                     resp_ready_i,
  output logic [DMI_DATA_WIDTH-1:0]      resp_data_o,
  output logic [DMI_OP_WIDTH-1:0]        resp_op_o,
  output logic                           dm_req_valid_o,
  input  logic                           dm_req_ready_i,
  output logic [DMI_ADDR_WIDTH-1:0]      dm_req_addr_o,
  output logic [DMI_DATA_WIDTH-1:0]      dm_req_data_o,
  output logic [DMI_OP_WIDTH-1:0]        dm_req_op_o,
  input  logic                           dm_resp_valid_i,
  output logic                           dm_resp_ready_o,
  input  logic [DMI_DATA_WIDTH-1:0]      dm_resp_data_i,
  input  logic [DMI_OP_WIDTH-1:0]        dm_resp_op_i,
  output logic [1:0]                     grant_o,
  output logic                           timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_RET
  } state_e;

  localparam bit          TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT_CYCLES);
  localparam logic [DMI_OP_WIDTH-1:0] OP_FAILED = DMI_OP_WIDTH'(2);

  state_e                     state_q, state_d;
  logic                       owner_q;
  logic                       last_grant_q;
  logic [15:0]                cnt_q;
  logic                       timeout_q;
  logic [DMI_ADDR_WIDTH-1:0]  addr_q;
  logic [DMI_DATA_WIDTH-1:0]  data_q;
  logic [DMI_OP_WIDTH-1:0]    op_q;
  logic [DMI_DATA_WIDTH-1:0]  resp_data_q;
  logic [DMI_OP_WIDTH-1:0]    resp_op_q;

  logic        accept;
  logic        pick;
  logic        timeout_hit;
  logic        in_flight;
  logic [16:0] cnt_inc;

  assign in_flight = (state_q == ST_REQ) || (state_q == ST_RESP);
  assign cnt_inc   = {1'b0, cnt_q} + 17'd1;

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    pick        = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i != 2'b00) begin
          accept  = 1'b1;
          pick    = (&req_valid_i) ? ~last_grant_q : req_valid_i[1];
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // A completing handshake always wins over an expiring counter.
        if (dm_req_ready_i) begin
          state_d = ST_RESP;
        end else if (TIMEOUT_EN && (cnt_inc >= TIMEOUT_LIM)) begin
          timeout_hit = 1'b1;
          state_d     = ST_RET;
        end
      end
      ST_RESP: begin
        if (dm_resp_valid_i) begin
          state_d = ST_RET;
        end else if (TIMEOUT_EN && (cnt_inc >= TIMEOUT_LIM)) begin
          timeout_hit = 1'b1;
          state_d     = ST_RET;
        end
      end
      ST_RET: begin
        if (resp_ready_i[owner_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge trst_i) begin
    if (trst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      op_q         <= '0;
      resp_data_q  <= '0;
      resp_op_q    <= '0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_hit;
      if (accept) begin
        owner_q <= pick;
        addr_q  <= req_addr_i[pick];
        data_q  <= req_data_i[pick];
        op_q    <= req_op_i[pick];
        cnt_q   <= '0;
      end else if (in_flight && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if ((state_q == ST_RESP) && dm_resp_valid_i) begin
        resp_data_q <= dm_resp_data_i;
        resp_op_q   <= dm_resp_op_i;
      end else if (timeout_hit) begin
        resp_data_q <= '0;
        resp_op_q   <= OP_FAILED;
      end
      if ((state_q == ST_RET) && resp_ready_i[owner_q]) last_grant_q <= owner_q;
    end
  end

  // Request accept is gated by reset so nothing is accepted while it is held.
  assign req_ready_o     = (accept && !trst_i) ? {pick, ~pick} : 2'b00;
  assign grant_o         = (state_q != ST_IDLE) ? {owner_q, ~owner_q} : 2'b00;
  assign resp_valid_o    = (state_q == ST_RET) ? {owner_q, ~owner_q} : 2'b00;
  assign resp_data_o     = resp_data_q;
  assign resp_op_o       = resp_op_q;
  assign dm_req_valid_o  = (state_q == ST_REQ);
  assign dm_req_addr_o   = addr_q;
  assign dm_req_data_o   = data_q;
  assign dm_req_op_o     = op_q;
  assign dm_resp_ready_o = (state_q != ST_RET);
  assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_riscv_dmi_arbiter.sv
// Self-checking bench for riscv_dmi_arbiter: arbitration table, timeout and
// reset corner sequences, then randomized transactions against a txn model.
module tb_riscv_dmi_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int OW = 2;
  localparam int TO = 8;

  logic                clk_i = 1'b0;
  logic                trst_i;
  logic [1:0]          req_valid_i;
  logic [1:0]          req_ready_o;
  logic [1:0][AW-1:0]  req_addr_i;
  logic [1:0][DW-1:0]  req_data_i;
  logic [1:0][OW-1:0]  req_op_i;
  logic [1:0]          resp_valid_o;
  logic [1:0]          resp_ready_i;
  logic [DW-1:0]       resp_data_o;
  logic [OW-1:0]       resp_op_o;
  logic                dm_req_valid_o;
  logic                dm_req_ready_i;
  logic [AW-1:0]       dm_req_addr_o;
  logic [DW-1:0]       dm_req_data_o;
  logic [OW-1:0]       dm_req_op_o;
  logic                dm_resp_valid_i;
  logic                dm_resp_ready_o;
  logic [DW-1:0]       dm_resp_data_i;
  logic [OW-1:0]       dm_resp_op_i;
  logic [1:0]          grant_o;
  logic                timeout_o;

  riscv_dmi_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .DMI_ADDR_WIDTH(AW),
    .DMI_DATA_WIDTH(DW),
    .DMI_OP_WIDTH  (OW)
  ) dut (
    .clk_i          (clk_i),
    .trst_i         (trst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .req_data_i     (req_data_i),
    .req_op_i       (req_op_i),
    .resp_valid_o   (resp_valid_o),
    .resp_ready_i   (resp_ready_i),
    .resp_data_o    (resp_data_o),
    .resp_op_o      (resp_op_o),
    .dm_req_valid_o (dm_req_valid_o),
    .dm_req_ready_i (dm_req_ready_i),
    .dm_req_addr_o  (dm_req_addr_o),
    .dm_req_data_o  (dm_req_data_o),
    .dm_req_op_o    (dm_req_op_o),
    .dm_resp_valid_i(dm_resp_valid_i),
    .dm_resp_ready_o(dm_resp_ready_o),
    .dm_resp_data_i (dm_resp_data_i),
    .dm_resp_op_i   (dm_resp_op_i),
    .grant_o        (grant_o),
    .timeout_o      (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int accept_cyc;
  int model_lg;

  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]    valid;
    logic [OW-1:0] op0;
    logic [OW-1:0] op1;
    logic [DW-1:0] rdata;
    logic [OW-1:0] rop;
    int            exp_idx;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh(input int idx);
    return (idx == 1) ? 2'b10 : 2'b01;
  endfunction

  // Transaction-level model: round-robin only matters when both request.
  function automatic int model_pick(input logic [1:0] v);
    if (v == 2'b11) return (model_lg == 0) ? 1 : 0;
    return v[1] ? 1 : 0;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  // Runs one transaction starting in IDLE; the DM and requester wait the given cycles.
  task automatic run_txn(input logic [1:0] valid, input int exp_idx,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic [OW-1:0] o0, input logic [OW-1:0] o1,
                         input int req_wait, input int resp_wait, input int ret_wait,
                         input logic [DW-1:0] rdata, input logic [OW-1:0] rop);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [OW-1:0] eo;
    ea = (exp_idx == 1) ? a1 : a0;
    ed = (exp_idx == 1) ? d1 : d0;
    eo = (exp_idx == 1) ? o1 : o0;
    req_valid_i   = valid;
    req_addr_i[0] = a0;  req_addr_i[1] = a1;
    req_data_i[0] = d0;  req_data_i[1] = d1;
    req_op_i[0]   = o0;  req_op_i[1]   = o1;
    #1;
    check("accept_ready", req_ready_o, oh(exp_idx));
    check("idle_grant", grant_o, 2'b00);
    accept_cyc = cyc;
    step();
    for (int w = 0; w <= req_wait; w++) begin
      check("req_valid", dm_req_valid_o, 1'b1);
      check("req_addr", dm_req_addr_o, ea);
      check("req_data", dm_req_data_o, ed);
      check("req_op", dm_req_op_o, eo);
      check("req_grant", grant_o, oh(exp_idx));
      check("busy_req_ready", req_ready_o, 2'b00);
      if (w == req_wait) dm_req_ready_i = 1'b1;
      step();
      dm_req_ready_i = 1'b0;
    end
    for (int w = 0; w <= resp_wait; w++) begin
      check("resp_dm_req_valid", dm_req_valid_o, 1'b0);
      check("resp_rv", resp_valid_o, 2'b00);
      check("resp_dm_ready", dm_resp_ready_o, 1'b1);
      if (w == resp_wait) begin
        dm_resp_valid_i = 1'b1;
        dm_resp_data_i  = rdata;
        dm_resp_op_i    = rop;
      end
      step();
      dm_resp_valid_i = 1'b0;
    end
    for (int w = 0; w <= ret_wait; w++) begin
      check("ret_rv", resp_valid_o, oh(exp_idx));
      check("ret_data", resp_data_o, rdata);
      check("ret_op", resp_op_o, rop);
      check("ret_dm_ready", dm_resp_ready_o, 1'b0);
      check("ret_req_ready", req_ready_o, 2'b00);
      check("ret_timeout", timeout_o, 1'b0);
      if (w == ret_wait) resp_ready_i = oh(exp_idx);
      step();
      resp_ready_i = 2'b00;
    end
    check("back_idle_rv", resp_valid_o, 2'b00);
    model_lg = exp_idx;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    int prev_accept;
    logic [1:0] v;
    int e;

    // Arbitration sequence from reset: last_grant starts at 1.
    tbl[0] = '{2'b11, 2'd1, 2'd2, 32'hCAFE_F00D, 2'd0, 0};
    tbl[1] = '{2'b11, 2'd1, 2'd2, 32'hCAFE_F00D, 2'd0, 1};
    tbl[2] = '{2'b01, 2'd0, 2'd0, 32'h0000_0011, 2'd0, 0};
    tbl[3] = '{2'b01, 2'd2, 2'd1, 32'h0000_0022, 2'd3, 0};
    tbl[4] = '{2'b11, 2'd2, 2'd2, 32'h0000_0033, 2'd0, 1};
    tbl[5] = '{2'b10, 2'd0, 2'd1, 32'h0000_0044, 2'd1, 1};
    tbl[6] = '{2'b11, 2'd0, 2'd0, 32'h0000_0055, 2'd2, 0};
    tbl[7] = '{2'b10, 2'd1, 2'd0, 32'h0000_0066, 2'd0, 1};

    trst_i          = 1'b1;
    req_valid_i     = 2'b11;
    req_addr_i      = '0;
    req_data_i      = '0;
    req_op_i        = '0;
    resp_ready_i    = 2'b00;
    dm_req_ready_i  = 1'b0;
    dm_resp_valid_i = 1'b0;
    dm_resp_data_i  = '0;
    dm_resp_op_i    = '0;
    model_lg        = 1;
    step();
    step();
    check("rst_req_ready", req_ready_o, 2'b00);
    check("rst_grant", grant_o, 2'b00);
    check("rst_resp_valid", resp_valid_o, 2'b00);
    check("rst_dm_req_valid", dm_req_valid_o, 1'b0);
    check("rst_dm_resp_ready", dm_resp_ready_o, 1'b1);
    check("rst_timeout", timeout_o, 1'b0);
    check("rst_resp_data", resp_data_o, '0);
    check("rst_dm_req_addr", dm_req_addr_o, '0);
    trst_i = 1'b0;

    prev_accept = 0;
    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].valid, tbl[i].exp_idx, 7'h11, 7'h22, 32'hA0A0_0000, 32'hB1B1_0001,
              tbl[i].op0, tbl[i].op1, 0, 0, 0, tbl[i].rdata, tbl[i].rop);
      if (i > 0) check("throughput", accept_cyc - prev_accept, 4);
      prev_accept = accept_cyc;
    end
    req_valid_i = 2'b00;
    step();

    // Timeout while the DM never accepts; a stray response in REQ is discarded.
    req_valid_i = 2'b01;
    #1;
    check("to_req_accept", req_ready_o, 2'b01);
    step();
    req_valid_i     = 2'b00;
    dm_resp_valid_i = 1'b1;
    dm_resp_data_i  = 32'hDEAD_BEEF;
    dm_resp_op_i    = 2'd1;
    k = 0;
    while (!timeout_o && k < 20) begin
      check("to_req_dm_valid", dm_req_valid_o, 1'b1);
      step();
      k++;
    end
    dm_resp_valid_i = 1'b0;
    check("to_req_latency", k, TO);
    check("to_req_rv", resp_valid_o, 2'b01);
    check("to_req_data", resp_data_o, 32'h0);
    check("to_req_op", resp_op_o, 2'd2);
    check("to_req_dm_valid_drop", dm_req_valid_o, 1'b0);
    step();
    check("to_req_pulse_end", timeout_o, 1'b0);
    check("to_req_rv_hold", resp_valid_o, 2'b01);
    resp_ready_i = 2'b01;
    step();
    resp_ready_i = 2'b00;
    check("to_req_idle", resp_valid_o, 2'b00);
    model_lg = 0;

    // Handshakes landing on the expiring cycle take priority over the timeout.
    req_valid_i = 2'b10;
    #1;
    check("prio_accept", req_ready_o, 2'b10);
    step();
    req_valid_i = 2'b00;
    for (int i = 0; i < TO - 1; i++) step();
    check("prio_still_req", dm_req_valid_o, 1'b1);
    dm_req_ready_i = 1'b1;
    step();
    dm_req_ready_i = 1'b0;
    check("prio_no_timeout_req", timeout_o, 1'b0);
    check("prio_in_resp", dm_req_valid_o, 1'b0);
    check("prio_no_rv", resp_valid_o, 2'b00);
    dm_resp_valid_i = 1'b1;
    dm_resp_data_i  = 32'h5A5A_5A5A;
    dm_resp_op_i    = 2'd1;
    step();
    dm_resp_valid_i = 1'b0;
    check("prio_no_timeout_resp", timeout_o, 1'b0);
    check("prio_rv", resp_valid_o, 2'b10);
    check("prio_data", resp_data_o, 32'h5A5A_5A5A);
    check("prio_op", resp_op_o, 2'd1);
    resp_ready_i = 2'b10;
    step();
    resp_ready_i = 2'b00;
    model_lg = 1;

    // Timeout while waiting for the DM response.
    req_valid_i = 2'b01;
    #1;
    check("to_resp_accept", req_ready_o, 2'b01);
    step();
    req_valid_i    = 2'b00;
    dm_req_ready_i = 1'b1;
    step();
    dm_req_ready_i = 1'b0;
    k = 1;
    while (!timeout_o && k < 20) begin
      step();
      k++;
    end
    check("to_resp_latency", k, TO);
    check("to_resp_rv", resp_valid_o, 2'b01);
    check("to_resp_data", resp_data_o, 32'h0);
    check("to_resp_op", resp_op_o, 2'd2);
    resp_ready_i = 2'b01;
    step();
    resp_ready_i = 2'b00;
    model_lg = 0;

    // Reset in the middle of RESP, then a stray DM response.
    req_valid_i = 2'b11;
    #1;
    check("mid_rst_accept", req_ready_o, 2'b10);
    step();
    dm_req_ready_i = 1'b1;
    step();
    dm_req_ready_i = 1'b0;
    #1;
    trst_i = 1'b1;
    #1;
    check("async_rst_grant", grant_o, 2'b00);
    check("async_rst_req_ready", req_ready_o, 2'b00);
    check("async_rst_dm_resp_ready", dm_resp_ready_o, 1'b1);
    check("async_rst_dm_req_addr", dm_req_addr_o, '0);
    check("async_rst_rv", resp_valid_o, 2'b00);
    step();
    req_valid_i     = 2'b00;
    trst_i          = 1'b0;
    model_lg        = 1;
    dm_resp_valid_i = 1'b1;
    dm_resp_data_i  = 32'h1234_5678;
    step();
    dm_resp_valid_i = 1'b0;
    check("stray_rv", resp_valid_o, 2'b00);
    check("stray_grant", grant_o, 2'b00);
    step();
    check("stray_rv_later", resp_valid_o, 2'b00);

    // First simultaneous request after reset goes to requester 0.
    run_txn(2'b11, 0, 7'h01, 7'h02, 32'h1, 32'h2, 2'd1, 2'd1, 0, 0, 0, 32'h0BAD_F00D, 2'd0);
    // Requester 1 write held off by the DM for 5 cycles.
    run_txn(2'b11, 1, 7'h05, 7'h10, 32'h7, 32'h1, 2'd1, 2'd2, 5, 0, 0, 32'h0, 2'd0);
    // Requester 0 slow to take its response while requester 1 waits.
    run_txn(2'b11, 0, 7'h03, 7'h04, 32'h3, 32'h4, 2'd1, 2'd1, 0, 1, 3, 32'h7777_0000, 2'd0);
    run_txn(2'b11, 1, 7'h03, 7'h04, 32'h3, 32'h4, 2'd1, 2'd1, 0, 0, 0, 32'h8888_0000, 2'd0);

    // Randomized traffic against the transaction-level model.
    for (int i = 0; i < 40; i++) begin
      v = 2'($urandom_range(1, 3));
      e = model_pick(v);
      run_txn(v, e, 7'($urandom), 7'($urandom), $urandom, $urandom,
              2'($urandom), 2'($urandom),
              $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom, 2'($urandom));
    end
    req_valid_i = 2'b00;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
